// File: rtl/ucsbece154b_gshare_bp_if.sv
// Predictor-to-datapath bundle for ucsbece154b_gshare_bp.
// master: the pipeline datapath (drives fetch/execute info, reads predictions).
// slave : the predictor.
// Signals:
//   stall_f_i/stall_d_i/flush_d_i/flush_e_i  pipeline hazard controls
//   pc_f_i, op_f_i                           fetch PC and opcode
//   predict_taken_f_o, predict_target_f_o    same-cycle prediction
//   pc_e_i, branch_e_i, jump_e_i, taken_e_i,
//   target_e_i, mispredict_e_i               resolved Execute outcome
//   stat_branches_o, stat_mispredicts_o      optional statistics
interface ucsbece154b_gshare_bp_if;
  logic        stall_f_i;
  logic        stall_d_i;
  logic        flush_d_i;
  logic        flush_e_i;
  logic [31:0] pc_f_i;
  logic [6:0]  op_f_i;
  logic        predict_taken_f_o;
  logic [31:0] predict_target_f_o;
  logic [31:0] pc_e_i;
  logic        branch_e_i;
  logic        jump_e_i;
  logic        taken_e_i;
  logic [31:0] target_e_i;
  logic        mispredict_e_i;
  logic [31:0] stat_branches_o;
  logic [31:0] stat_mispredicts_o;

  modport master (
    output stall_f_i, stall_d_i, flush_d_i, flush_e_i, pc_f_i, op_f_i,
           pc_e_i, branch_e_i, jump_e_i, taken_e_i, target_e_i, mispredict_e_i,
    input  predict_taken_f_o, predict_target_f_o, stat_branches_o, stat_mispredicts_o
  );

  modport slave (
    input  stall_f_i, stall_d_i, flush_d_i, flush_e_i, pc_f_i, op_f_i,
           pc_e_i, branch_e_i, jump_e_i, taken_e_i, target_e_i, mispredict_e_i,
    output predict_taken_f_o, predict_target_f_o, stat_branches_o, stat_mispredicts_o
  );
endinterface

// File: rtl/ucsbece154b_gshare_bp.sv
// Gshare branch predictor with a direct-mapped BTB.
// Predicts taken/target combinationally for the fetch PC, carries the
// {GHR, PHT index} context through D and E, trains from resolved Execute
// outcomes and repairs the GHR on a mispredict.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high
//   bp     ucsbece154b_gshare_bp_if.slave (fetch, execute, stats signals)
// Optional build macro: UCSBECE154B_BP_STATS_EN enables the saturating
// branch/mispredict counters; without it both stat outputs are tied to 0.
module ucsbece154b_gshare_bp #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input logic                  clk,
  input logic                  reset,
  ucsbece154b_gshare_bp_if.slave bp
);
  localparam int IW    = $clog2(NUM_BTB_ENTRIES);
  localparam int TW    = 30 - IW;
  localparam int N     = NUM_GHR_BITS;
  localparam int PHT_N = 1 << N;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [N-1:0] ghr;
    logic [N-1:0] idx;
  } ctx_t;

  logic                       btb_valid  [NUM_BTB_ENTRIES];
  logic [TW-1:0]              btb_tag    [NUM_BTB_ENTRIES];
  logic [31:0]                btb_target [NUM_BTB_ENTRIES];
  logic [NUM_BTB_ENTRIES-1:0] btb_jump;
  logic [1:0]                 pht        [PHT_N];
  logic [N-1:0]               ghr;
  ctx_t                       ctx_f, ctx_d, ctx_e;

  // Fetch-side lookup
  logic [IW-1:0] f_bidx;
  logic [TW-1:0] f_tag;
  logic [N-1:0]  f_pidx;
  logic          f_hit, f_taken;

  assign f_bidx = bp.pc_f_i[2 +: IW];
  assign f_tag  = bp.pc_f_i[31 -: TW];
  assign f_pidx = bp.pc_f_i[2 +: N] ^ ghr;
  assign f_hit  = btb_valid[f_bidx] && (btb_tag[f_bidx] == f_tag);

  always_comb begin
    f_taken = 1'b0;
    if (f_hit) begin
      if (bp.op_f_i == OP_JAL)         f_taken = 1'b1;
      else if (bp.op_f_i == OP_BRANCH) f_taken = pht[f_pidx][1];
    end
  end

  assign bp.predict_taken_f_o  = f_taken;
  assign bp.predict_target_f_o = f_taken ? btb_target[f_bidx] : 32'd0;

  // Execute-side write address
  logic [IW-1:0] e_bidx;
  logic [TW-1:0] e_tag;
  assign e_bidx = bp.pc_e_i[2 +: IW];
  assign e_tag  = bp.pc_e_i[31 -: TW];

  // Table training; reads in the same cycle see the pre-edge contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
      btb_jump <= '0;
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
    end else begin
      if (bp.branch_e_i) begin
        if (bp.taken_e_i) begin
          if (pht[ctx_e.idx] != 2'b11) pht[ctx_e.idx] <= pht[ctx_e.idx] + 2'd1;
          btb_valid[e_bidx]  <= 1'b1;
          btb_tag[e_bidx]    <= e_tag;
          btb_target[e_bidx] <= bp.target_e_i;
          btb_jump[e_bidx]   <= 1'b0;
        end else if (pht[ctx_e.idx] != 2'b00) begin
          pht[ctx_e.idx] <= pht[ctx_e.idx] - 2'd1;
        end
      end
      if (bp.jump_e_i) begin
        btb_valid[e_bidx]  <= 1'b1;
        btb_tag[e_bidx]    <= e_tag;
        btb_target[e_bidx] <= bp.target_e_i;
        btb_jump[e_bidx]   <= 1'b1;
      end
    end
  end

  // GHR: recovery from the E-stage snapshot overrides the speculative shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else if (bp.mispredict_e_i) begin
      if (bp.branch_e_i)    ghr <= {ctx_e.ghr[N-2:0], bp.taken_e_i};
      else if (bp.jump_e_i) ghr <= ctx_e.ghr;
    end else if (bp.op_f_i == OP_BRANCH && !bp.stall_f_i) begin
      ghr <= {ghr[N-2:0], f_taken};
    end
  end

  // Context pipeline: pre-shift GHR and PHT index follow the instruction.
  assign ctx_f = {ghr, f_pidx};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctx_d <= '0;
      ctx_e <= '0;
    end else begin
      if (bp.flush_d_i)       ctx_d <= '0;
      else if (!bp.stall_d_i) ctx_d <= ctx_f;
      if (bp.flush_e_i)       ctx_e <= '0;
      else                    ctx_e <= ctx_d;
    end
  end

`ifdef UCSBECE154B_BP_STATS_EN
  logic [31:0] stat_br, stat_mp;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_br <= '0;
      stat_mp <= '0;
    end else begin
      if ((bp.branch_e_i || bp.jump_e_i) && stat_br != 32'hFFFF_FFFF) stat_br <= stat_br + 32'd1;
      if (bp.mispredict_e_i && stat_mp != 32'hFFFF_FFFF)              stat_mp <= stat_mp + 32'd1;
    end
  end
  assign bp.stat_branches_o    = stat_br;
  assign bp.stat_mispredicts_o = stat_mp;
`else
  assign bp.stat_branches_o    = 32'd0;
  assign bp.stat_mispredicts_o = 32'd0;
`endif

  // Byte-offset PC bits and the stored jump flag have no reader.
  logic unused_bits;
  assign unused_bits = ^{bp.pc_f_i[1:0], bp.pc_e_i[1:0], btb_jump};
endmodule

// File: tb/tb_ucsbece154b_gshare_bp.sv
module tb_ucsbece154b_gshare_bp;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  ucsbece154b_gshare_bp_if bp_if ();

  ucsbece154b_gshare_bp #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bp   (bp_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [6:0] op);
    bp_if.pc_f_i = pc;
    bp_if.op_f_i = op;
    #1;
  endtask

  initial begin
    bp_if.stall_f_i = 0; bp_if.stall_d_i = 0; bp_if.flush_d_i = 0; bp_if.flush_e_i = 0;
    bp_if.pc_f_i = 0; bp_if.op_f_i = 0; bp_if.pc_e_i = 0; bp_if.branch_e_i = 0;
    bp_if.jump_e_i = 0; bp_if.taken_e_i = 0; bp_if.target_e_i = 0; bp_if.mispredict_e_i = 0;
    reset = 0;
    #1 reset = 1;
    #1;
    // Reset state
    check("rst_taken",  32'(bp_if.predict_taken_f_o), 32'd0);
    check("rst_target", bp_if.predict_target_f_o, 32'd0);
    check("rst_ghr",    32'(dut.ghr), 32'd0);
    check("rst_ctx_d",  32'(dut.ctx_d), 32'd0);
    check("rst_ctx_e",  32'(dut.ctx_e), 32'd0);
    check("rst_stat_br", bp_if.stat_branches_o, 32'd0);
    check("rst_stat_mp", bp_if.stat_mispredicts_o, 32'd0);
    for (int i = 0; i < 32; i++) check($sformatf("rst_pht%0d", i), 32'(dut.pht[i]), 32'd1);
    @(negedge clk) reset = 0;
    tick();

    // Cold branch fetch: no BTB hit
    fetch(32'h10, OP_BRANCH);
    check("cold_taken",  32'(bp_if.predict_taken_f_o), 32'd0);
    check("cold_target", bp_if.predict_target_f_o, 32'd0);
    bp_if.op_f_i = 0;

    // jal training; same-cycle read sees old contents
    bp_if.jump_e_i = 1; bp_if.pc_e_i = 32'h20; bp_if.target_e_i = 32'h80;
    fetch(32'h20, OP_JAL);
    check("jal_nobypass", 32'(bp_if.predict_taken_f_o), 32'd0);
    tick();
    bp_if.jump_e_i = 0;
    #1;
    check("jal_taken",  32'(bp_if.predict_taken_f_o), 32'd1);
    check("jal_target", bp_if.predict_target_f_o, 32'h80);

    // Branch at 0x40 with GHR 0 -> PHT index 16
    fetch(32'h40, OP_BRANCH);
    tick();
    check("ctx_d_br", 32'(dut.ctx_d), 32'h010);
    bp_if.op_f_i = 0;
    tick();
    check("ctx_e_br", 32'(dut.ctx_e), 32'h010);
    bp_if.branch_e_i = 1; bp_if.taken_e_i = 1; bp_if.pc_e_i = 32'h40; bp_if.target_e_i = 32'h100;
    tick();
    check("pht16_10", 32'(dut.pht[16]), 32'd2);
    tick();
    check("pht16_11", 32'(dut.pht[16]), 32'd3);
    bp_if.branch_e_i = 0; bp_if.taken_e_i = 0;
    fetch(32'h40, OP_BRANCH);
    check("br_taken",  32'(bp_if.predict_taken_f_o), 32'd1);
    check("br_target", bp_if.predict_target_f_o, 32'h100);
    tick();
    check("ghr_shift1", 32'(dut.ghr), 32'd1);

    // Mispredict recovery beats the fetch shift
    bp_if.op_f_i = 0;
    tick();
    check("ctx_e_snap", 32'(dut.ctx_e), 32'h010);
    bp_if.mispredict_e_i = 1; bp_if.branch_e_i = 1; bp_if.taken_e_i = 0; bp_if.pc_e_i = 32'h40;
    fetch(32'h40, OP_BRANCH);
    check("mp_fetch_nt", 32'(bp_if.predict_taken_f_o), 32'd0);
    tick();
    check("ghr_recover_br", 32'(dut.ghr), 32'd0);
    check("pht16_dec", 32'(dut.pht[16]), 32'd2);
    bp_if.branch_e_i = 0; bp_if.op_f_i = 0;
    // jal in E restores the snapshot unchanged (ctx_e.ghr = 1)
    bp_if.jump_e_i = 1; bp_if.pc_e_i = 32'h20; bp_if.target_e_i = 32'h80;
    tick();
    check("ghr_recover_jal", 32'(dut.ghr), 32'd1);
    bp_if.jump_e_i = 0; bp_if.mispredict_e_i = 0;

    // Stalls: GHR and F->D context hold
    bp_if.stall_f_i = 1; bp_if.stall_d_i = 1;
    fetch(32'h40, OP_BRANCH);
    tick();
    check("stall_ghr",   32'(dut.ghr), 32'd1);
    check("stall_ctx_d", 32'(dut.ctx_d), 32'h010);
    bp_if.stall_f_i = 0; bp_if.stall_d_i = 0; bp_if.op_f_i = 0;
    tick();
    check("unstall_ctx_d", 32'(dut.ctx_d), 32'h031);

    // Flushes
    bp_if.flush_d_i = 1;
    tick();
    check("flush_d_ctx_d", 32'(dut.ctx_d), 32'd0);
    check("flush_d_ctx_e", 32'(dut.ctx_e), 32'h031);
    bp_if.flush_d_i = 0; bp_if.flush_e_i = 1;
    tick();
    check("flush_e_ctx_e", 32'(dut.ctx_e), 32'd0);
    bp_if.flush_e_i = 0;
    bp_if.branch_e_i = 1; bp_if.taken_e_i = 0; bp_if.pc_e_i = 32'h40;
    tick();
    bp_if.branch_e_i = 0;
    check("flush_pht0",  32'(dut.pht[0]), 32'd0);
    check("flush_pht17", 32'(dut.pht[17]), 32'd1);

    // BTB conflict: 0xA0 shares index 8 with 0x20
    bp_if.jump_e_i = 1; bp_if.pc_e_i = 32'hA0; bp_if.target_e_i = 32'h200;
    tick();
    bp_if.jump_e_i = 0;
    fetch(32'h20, OP_JAL);
    check("conflict_old_taken",  32'(bp_if.predict_taken_f_o), 32'd0);
    check("conflict_old_target", bp_if.predict_target_f_o, 32'd0);
    fetch(32'hA0, OP_JAL);
    check("conflict_new_taken",  32'(bp_if.predict_taken_f_o), 32'd1);
    check("conflict_new_target", bp_if.predict_target_f_o, 32'h200);
    fetch(32'hA0, OP_JALR);
    check("jalr_never", 32'(bp_if.predict_taken_f_o), 32'd0);

    // Asynchronous reset mid-cycle
    fetch(32'hA0, OP_JAL);
    reset = 1;
    #1;
    check("async_taken", 32'(bp_if.predict_taken_f_o), 32'd0);
    check("async_ghr",   32'(dut.ghr), 32'd0);
    check("async_pht16", 32'(dut.pht[16]), 32'd1);
    bp_if.op_f_i = 0;
    @(negedge clk) reset = 0;
    tick();

    // Statistics: 3 resolved branches, 1 mispredict
    bp_if.branch_e_i = 1; bp_if.taken_e_i = 1; bp_if.pc_e_i = 32'h40; bp_if.target_e_i = 32'h100;
    tick();
    bp_if.mispredict_e_i = 1;
    tick();
    bp_if.mispredict_e_i = 0;
    tick();
    bp_if.branch_e_i = 0; bp_if.taken_e_i = 0;
    tick();
`ifdef UCSBECE154B_BP_STATS_EN
    check("stat_br", bp_if.stat_branches_o, 32'd3);
    check("stat_mp", bp_if.stat_mispredicts_o, 32'd1);
`else
    check("stat_br", bp_if.stat_branches_o, 32'd0);
    check("stat_mp", bp_if.stat_mispredicts_o, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ucsbece154b_gshare_bp.md
# ucsbece154b_gshare_bp

Gshare branch predictor with branch target buffer (BTB) for the 5-stage RISC-V pipeline. It sits upstream of the fetch-stage PC mux and supplies a same-cycle taken/target prediction for the fetch PC. It carries the prediction context through D and E. It trains its tables from resolved Execute-stage outcomes and restores the global history register (GHR) on a mispredict.

## Interface
- NUM_BTB_ENTRIES, 32: direct-mapped BTB entries; power of two, ≥4.
- NUM_GHR_BITS, 5: GHR width. The PHT has 2^NUM_GHR_BITS two-bit counters.

- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- stall_f_i  in  1  fetch stall; GHR speculative shift suppressed.
- stall_d_i  in  1  holds the F→D context register.
- flush_d_i  in  1  clears the F→D context register.
- flush_e_i  in  1  clears the D→E context register.
- pc_f_i  in  32  fetch PC.
- op_f_i  in  7  opcode of the fetched instruction.
- predict_taken_f_o  out  1  predicted taken.
- predict_target_f_o  out  32  predicted target; equals BTB target, or 0 when not taken.
- pc_e_i  in  32  PC of the Execute instruction.
- branch_e_i  in  1  Execute instruction is a conditional branch.
- jump_e_i  in  1  Execute instruction is jal.
- taken_e_i  in  1  resolved branch outcome.
- target_e_i  in  32  resolved target (PCE+imm).
- mispredict_e_i  in  1  Execute-stage mispredict (datapath-detected).
- stat_branches_o  out  32  resolved branch+jal count.
- stat_mispredicts_o  out  32  mispredict count.

## Operation
- Index fields:
  - BTB index: pc[2 +: log2(NUM_BTB_ENTRIES)].
  - BTB tag: remaining upper PC bits.
  - PHT index: pc[2 +: NUM_GHR_BITS] XOR GHR.
- BTB entry contents: valid, tag, target[31:0], is_jump.
- Prediction (combinational from pc_f_i, op_f_i):
  - Hit = valid & tag match.
  - op_f_i=1101111 (jal) & hit → taken.
  - op_f_i=1100011 (branch) & hit → PHT[idx][1].
  - Otherwise not taken. jalr (1100111) is never predicted.
- Speculative GHR shift: on a branch opcode with !stall_f_i and !mispredict_e_i, GHR <= {GHR[N-2:0], predicted bit}, regardless of hit.
- Context pipeline: {GHR-before-shift, PHT index} registered F→D then D→E.
  - F→D: hold on stall_d_i; clear on flush_d_i.
  - D→E: clear on flush_e_i.
- Training at the posedge when branch_e_i is high:
  - PHT[E index] saturating increment if taken_e_i, else saturating decrement. Range 00..11.
  - If taken_e_i: BTB[pc_e_i] <= {1, tag, target_e_i, 0}.
- Training at the posedge when jump_e_i is high: BTB[pc_e_i] <= {1, tag, target_e_i, 1}. No PHT change.
- Recovery on mispredict_e_i (priority over speculative shift):
  - Branch in E: GHR <= {ghr_e[N-2:0], taken_e_i}.
  - Jal in E: GHR <= ghr_e.

## Timing
- Prediction is combinational, with zero latency from pc_f_i.
- Table writes take effect at the posedge. A same-cycle read of an entry being written returns the old value; there is no bypass.
- Reset state:
  - All BTB valid bits 0; all PHT counters 01 (weakly not-taken).
  - GHR 0; context registers 0.
  - predict_taken_f_o 0, predict_target_f_o 0.
  - Stats counters 0.
- Reset mid-operation clears all of the above immediately (asynchronous).
- A simultaneous E training write and F prediction to the same index are independent; the write wins at the edge.
- BTB conflict: a new tag overwrites the old entry (no associativity).
- GHR wrap: the oldest bit is discarded on each shift.

## Configuration
- Macro UCSBECE154B_BP_STATS_EN.
- Defined:
  - stat_branches_o increments each cycle that branch_e_i|jump_e_i is high.
  - stat_mispredicts_o increments each cycle that mispredict_e_i is high.
  - Both saturate at 0xFFFFFFFF.
- Undefined: the counters are not built; both outputs are tied to 0.

## Test plan
- Reset, then pc_f_i=0x10, op=branch → predict_taken 0, target 0. PHT entries read back as 01.
- Resolve jal at pc_e=0x20, target 0x80. Later fetch 0x20 with op=jal → taken=1, target=0x80.
- Branch at 0x40 resolved taken twice (PHT 01→10→11), target 0x100. Next fetch at the same GHR → taken=1, target=0x100.
- GHR=00000, fetch branch predicted taken → GHR=00001. Mispredict in E with ghr_e=00000 and taken=0 → GHR=00000; the fetch shift that cycle is ignored.
- stall_f_i=1 with branch op → GHR unchanged. stall_d_i=1 → F→D context held. flush_e_i → E context 0, no training on its index.
- With UCSBECE154B_BP_STATS_EN: 3 branches and 1 mispredict → stats 3/1. Without the macro → 0/0.
